seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 2..16.
REQ-002 Parameter SEG_W, default 8: segment bus width per digit, including the decimal point.
REQ-003 Parameter PRESCALE, default 1000: clock cycles per digit slot; legal when PRESCALE >= BLANK+2.
REQ-004 Parameter BLANK, default 16: cycles at the start of each slot with all anodes off (anti-ghosting); legal when BLANK >= 1.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 seg_in  input  DIGITS*SEG_W  segment patterns, active-low; digit i occupies bits [i*SEG_W +: SEG_W].
REQ-008 digit_en  input  DIGITS  per-digit enable; 0 keeps that digit dark for its slot.
REQ-009 seg_out  output  SEG_W  registered segment drive, active-low.
REQ-010 anode  output  DIGITS  registered anode drive, active-low, at most one bit low.
REQ-011 scan_idx  output  clog2(DIGITS)  index of the current slot.
REQ-012 frame_tick  output  1  one-cycle pulse marking the start of each new frame.

Function
REQ-013 Slot counter cnt, clog2(PRESCALE) bits, SHALL count 0..PRESCALE-1 and return to 0 when it reaches PRESCALE-1.
REQ-014 On the cnt wrap, scan_idx SHALL advance by 1; DIGITS-1 SHALL wrap to 0, including non-power-of-two DIGITS.
REQ-015 Blank window, cycles with cnt in 0..BLANK-1: anode SHALL be all ones and seg_out SHALL be all ones.
REQ-016 At the edge where cnt goes BLANK-1 -> BLANK, the block SHALL latch seg_in slice [scan_idx] and digit_en[scan_idx].
REQ-017 Display window, cnt in BLANK..PRESCALE-1, digit enabled: anode[scan_idx] = 0, other anode bits 1, seg_out = latched slice.
REQ-018 Display window, digit disabled: anode all ones, seg_out all ones; the slot still lasts PRESCALE cycles, so the scan period is constant.
REQ-019 seg_in and digit_en changes during a display window SHALL NOT affect outputs until the next latch edge (no tearing).
REQ-020 anode and seg_out SHALL change on the same clock edge, with no cycle in which anode is low and seg_out is stale.
REQ-021 frame_tick SHALL be 1 during cnt == 0 of slot 0 only, and SHALL NOT pulse in the first slot 0 after reset.
REQ-022 Duty per enabled digit SHALL be (PRESCALE-BLANK)/(DIGITS*PRESCALE).

Reset
REQ-023 While rst_n = 0: cnt = 0, scan_idx = 0, anode all ones, seg_out all ones, frame_tick = 0, latched data all ones, latched enable = 0.
REQ-024 Assertion of rst_n mid-slot SHALL blank the outputs immediately (asynchronously), with no clock edge required.
REQ-025 The first rising edge after rst_n deasserts SHALL start slot 0 with cnt = 0.

Structure
REQ-026 A shared package seg_pkg SHALL hold the all-ones blank-pattern helper and the anode one-cold decode function.
REQ-027 The prescaler SHALL be a sub-module scan_prescaler (parameter PRESCALE) providing cnt and a wrap strobe.
REQ-028 All outputs SHALL come directly from flops.

Verification (DIGITS=4, SEG_W=8, PRESCALE=8, BLANK=2)
REQ-029 Reset release, seg_in = 0x11223344, digit_en = 4'hF -> cycles 0-1 anode F; cycles 2-7 anode E, seg_out 0x44; cycles 10-15 anode D, seg_out 0x33; pattern repeats every 32 cycles.
REQ-030 digit_en = 4'b1011 -> slot 2 shows anode F and seg_out FF for 8 cycles; the other slots are unchanged; the period stays 32.
REQ-031 seg_in slice 0 changes 0x44 -> 0x55 at cnt = 4 of slot 0 -> seg_out stays 0x44 until the next slot-0 latch, then becomes 0x55.
REQ-032 Free run -> frame_tick pulses at cycles 32, 64, 96 (not 0), one cycle wide; scan_idx is 0 on each pulse.
REQ-033 rst_n low at cnt = 5 of slot 2 -> anode F and seg_out FF before the next edge; after release, the sequence restarts at slot 0.
REQ-034 Run DIGITS=3, PRESCALE=5, BLANK=1 -> scan_idx runs 0,1,2,0; at most one anode bit is low, checked every cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: the all-ones
// blank pattern and the one-cold anode decode used by every digit slot.
package seg_pkg;

    // Upper bounds the helpers are sized for; callers cast down to their width.
    localparam int MAX_DIGITS = 16;
    localparam int MAX_SEG_W  = 32;
    localparam int IDX_MAX_W  = 4;

    // Segments and anodes are active-low, so "dark" is all ones.
    function automatic logic [MAX_SEG_W-1:0] blank_pattern();
        return '1;
    endfunction

    // One-cold anode decode: only the selected digit is driven low.
    function automatic logic [MAX_DIGITS-1:0] anode_onecold(input logic [IDX_MAX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] a;
        a      = '1;
        a[idx] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer: counts 0..PRESCALE-1 while enabled and flags the last cycle of
// each slot so the scanner can advance to the next digit on the same edge.
module scan_prescaler #(
    parameter int PRESCALE = 1000,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    // Wrap is asserted during the final cycle of a slot; the counter returns to 0 on that edge.
    assign wrap = en && (cnt == LAST);

    // Free-running slot counter, held at 0 until the scanner starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed display driver. Each digit owns a slot of PRESCALE cycles:
// a blank window of BLANK cycles with every anode off (suppresses ghosting),
// then a display window showing a pattern captured once at the blank/display
// boundary so input changes mid-slot never tear the visible digit.
module seg_scan_mux import seg_pkg::*; #(
    parameter int DIGITS   = 4,
    parameter int SEG_W    = 8,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIGITS*SEG_W-1:0]   seg_in,
    input  logic [DIGITS-1:0]         digit_en,
    output logic [SEG_W-1:0]          seg_out,
    output logic [DIGITS-1:0]         anode,
    output logic [$clog2(DIGITS)-1:0] scan_idx,
    output logic                      frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [SEG_W-1:0]  SEG_BLANK = SEG_W'(blank_pattern());
    localparam logic [DIGITS-1:0] ANODE_OFF = '1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    // Scanner has seen its first edge after reset; slot 0 starts from that edge.
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    // Pattern and enable captured at the start of the display window.
    logic [SEG_W-1:0] lat_seg;
    logic             lat_en;

    logic             last_digit;
    logic             latch_edge;
    logic             enter_blank;
    logic [SEG_W-1:0] cur_seg;
    logic             cur_en;
    logic [DIGITS-1:0] anode_sel;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Slot decode: where the next edge takes us and what the current digit would show.
    always_comb begin
        last_digit  = (scan_idx == IDX_LAST);
        latch_edge  = run && (int'(cnt) == BLANK - 1);
        enter_blank = !run || wrap || ((int'(cnt) + 1) < BLANK);
        cur_seg     = seg_in[int'(scan_idx) * SEG_W +: SEG_W];
        cur_en      = digit_en[scan_idx];
        anode_sel   = DIGITS'(anode_onecold(IDX_MAX_W'(scan_idx)));
    end

    // Scan sequencing: start flag, digit index and the frame-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
        end else begin
            run        <= 1'b1;
            frame_tick <= wrap && last_digit;
            if (wrap) begin
                scan_idx <= last_digit ? '0 : scan_idx + 1'b1;
            end
        end
    end

    // Capture the current digit's pattern and enable at the blank/display boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_seg <= SEG_BLANK;
            lat_en  <= 1'b0;
        end else if (latch_edge) begin
            lat_seg <= cur_seg;
            lat_en  <= cur_en;
        end
    end

    // Output drive: anode and segments always move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_BLANK;
            anode   <= ANODE_OFF;
        end else if (latch_edge) begin
            // Use the freshly sampled values so the display window starts with current data.
            seg_out <= cur_en ? cur_seg   : SEG_BLANK;
            anode   <= cur_en ? anode_sel : ANODE_OFF;
        end else if (enter_blank) begin
            seg_out <= SEG_BLANK;
            anode   <= ANODE_OFF;
        end else begin
            seg_out <= lat_en ? lat_seg   : SEG_BLANK;
            anode   <= lat_en ? anode_sel : ANODE_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-digit instance (PRESCALE=8, BLANK=2) and a
// 3-digit instance (PRESCALE=5, BLANK=1). Expected outputs come from a
// cycle-number model: cycle k after start lies in slot k/P, position k%P.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] seg_in;
    logic [3:0]  digit_en;
    logic [7:0]  seg_out;
    logic [3:0]  anode;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    logic        rst_n_b;
    logic [23:0] seg_in_b;
    logic [2:0]  digit_en_b;
    logic [7:0]  seg_out_b;
    logic [2:0]  anode_b;
    logic [1:0]  scan_idx_b;
    logic        frame_tick_b;

    int checks;
    int errors;

    seg_scan_mux #(.DIGITS(4), .SEG_W(8), .PRESCALE(8), .BLANK(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
        .seg_out    (seg_out),
        .anode      (anode),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    seg_scan_mux #(.DIGITS(3), .SEG_W(8), .PRESCALE(5), .BLANK(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .seg_in     (seg_in_b),
        .digit_en   (digit_en_b),
        .seg_out    (seg_out_b),
        .anode      (anode_b),
        .scan_idx   (scan_idx_b),
        .frame_tick (frame_tick_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    function automatic int ref_idx(int k, int d, int p);
        return (k / p) % d;
    endfunction

    function automatic logic [15:0] ref_anode(int k, int d, int p, int b, logic en);
        logic [15:0] a;
        a = 16'hFFFF;
        if ((k % p) >= b && en) a[ref_idx(k, d, p)] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] ref_seg(int k, int p, int b, logic en, logic [7:0] lat);
        return ((k % p) >= b && en) ? lat : 8'hFF;
    endfunction

    function automatic logic ref_frame(int k, int d, int p);
        return (k > 0) && (k % (d * p) == 0);
    endfunction

    // driver tasks
    task automatic restart_a();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        seg_in = $urandom;
        digit_en = 4'hF;
        repeat (3) @(negedge clk);
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode got=%h exp=f", anode); end
        checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=ff", seg_out); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame_tick); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", scan_idx); end
        checks++; if (anode_b !== 3'h7) begin errors++; $display("FAIL reset_anode_b got=%h exp=7", anode_b); end
    endtask

    task automatic test_basic();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        int          on_cnt;
        m_seg = 8'hFF; m_en = 1'b0; on_cnt = 0;
        seg_in = 32'h11223344; digit_en = 4'hF;
        restart_a();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 4, 8, 2, m_en);
            checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL basic_anode cyc=%0d got=%h exp=%h", k, anode, ea[3:0]); end
            checks++; if (seg_out !== ref_seg(k, 8, 2, m_en, m_seg)) begin errors++; $display("FAIL basic_seg cyc=%0d got=%h exp=%h", k, seg_out, ref_seg(k, 8, 2, m_en, m_seg)); end
            checks++; if (scan_idx !== 2'(ref_idx(k, 4, 8))) begin errors++; $display("FAIL basic_idx cyc=%0d got=%0d exp=%0d", k, scan_idx, ref_idx(k, 4, 8)); end
            checks++; if (frame_tick !== ref_frame(k, 4, 8)) begin errors++; $display("FAIL basic_frame cyc=%0d got=%b exp=%b", k, frame_tick, ref_frame(k, 4, 8)); end
            if (k >= 32 && k < 64 && anode[0] === 1'b0) on_cnt++;
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
        checks++; if (on_cnt != 6) begin errors++; $display("FAIL basic_duty got=%0d exp=6", on_cnt); end
    endtask

    task automatic test_disabled();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        m_seg = 8'hFF; m_en = 1'b0;
        seg_in = 32'h11223344; digit_en = 4'b1011;
        restart_a();
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 4, 8, 2, m_en);
            checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL dis_anode cyc=%0d got=%h exp=%h", k, anode, ea[3:0]); end
            checks++; if (seg_out !== ref_seg(k, 8, 2, m_en, m_seg)) begin errors++; $display("FAIL dis_seg cyc=%0d got=%h exp=%h", k, seg_out, ref_seg(k, 8, 2, m_en, m_seg)); end
            checks++; if (frame_tick !== ref_frame(k, 4, 8)) begin errors++; $display("FAIL dis_frame cyc=%0d got=%b exp=%b", k, frame_tick, ref_frame(k, 4, 8)); end
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
    endtask

    task automatic test_no_tear();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        m_seg = 8'hFF; m_en = 1'b0;
        seg_in = 32'h11223344; digit_en = 4'hF;
        restart_a();
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 4, 8, 2, m_en);
            checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL tear_anode cyc=%0d got=%h exp=%h", k, anode, ea[3:0]); end
            checks++; if (seg_out !== ref_seg(k, 8, 2, m_en, m_seg)) begin errors++; $display("FAIL tear_seg cyc=%0d got=%h exp=%h", k, seg_out, ref_seg(k, 8, 2, m_en, m_seg)); end
            if (k == 6) begin checks++; if (seg_out !== 8'h44) begin errors++; $display("FAIL tear_hold got=%h exp=44", seg_out); end end
            if (k == 34) begin checks++; if (seg_out !== 8'h55) begin errors++; $display("FAIL tear_update got=%h exp=55", seg_out); end end
            if (k == 4) seg_in[7:0] = 8'h55;
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
    endtask

    task automatic test_random();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        m_seg = 8'hFF; m_en = 1'b0;
        seg_in = $urandom; digit_en = 4'($urandom_range(0, 15));
        restart_a();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 4, 8, 2, m_en);
            checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL rand_anode cyc=%0d got=%h exp=%h", k, anode, ea[3:0]); end
            checks++; if (seg_out !== ref_seg(k, 8, 2, m_en, m_seg)) begin errors++; $display("FAIL rand_seg cyc=%0d got=%h exp=%h", k, seg_out, ref_seg(k, 8, 2, m_en, m_seg)); end
            if ($urandom_range(0, 3) == 0) begin seg_in = $urandom; digit_en = 4'($urandom_range(0, 15)); end
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        m_seg = 8'hFF; m_en = 1'b0;
        seg_in = 32'h11223344; digit_en = 4'hF;
        restart_a();
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
        ea = ref_anode(21, 4, 8, 2, m_en);
        checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL arst_pre got=%h exp=%h", anode, ea[3:0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL arst_anode got=%h exp=f", anode); end
        checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL arst_seg got=%h exp=ff", seg_out); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL arst_idx got=%0d exp=0", scan_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        m_seg = 8'hFF; m_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 4, 8, 2, m_en);
            checks++; if (anode !== ea[3:0]) begin errors++; $display("FAIL arst_re_anode cyc=%0d got=%h exp=%h", k, anode, ea[3:0]); end
            checks++; if (scan_idx !== 2'(ref_idx(k, 4, 8))) begin errors++; $display("FAIL arst_re_idx cyc=%0d got=%0d exp=%0d", k, scan_idx, ref_idx(k, 4, 8)); end
            if (k % 8 == 1) begin m_seg = seg_in[ref_idx(k, 4, 8) * 8 +: 8]; m_en = digit_en[ref_idx(k, 4, 8)]; end
        end
    endtask

    task automatic test_three_digit();
        logic [15:0] ea;
        logic [7:0]  m_seg;
        logic        m_en;
        m_seg = 8'hFF; m_en = 1'b0;
        seg_in_b = 24'($urandom); digit_en_b = 3'b111;
        @(negedge clk);
        rst_n_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            ea = ref_anode(k, 3, 5, 1, m_en);
            checks++; if (anode_b !== ea[2:0]) begin errors++; $display("FAIL d3_anode cyc=%0d got=%h exp=%h", k, anode_b, ea[2:0]); end
            checks++; if ($countones(~anode_b) > 1) begin errors++; $display("FAIL d3_onecold cyc=%0d got=%h exp=at_most_one_low", k, anode_b); end
            checks++; if (scan_idx_b !== 2'(ref_idx(k, 3, 5))) begin errors++; $display("FAIL d3_idx cyc=%0d got=%0d exp=%0d", k, scan_idx_b, ref_idx(k, 3, 5)); end
            checks++; if (seg_out_b !== ref_seg(k, 5, 1, m_en, m_seg)) begin errors++; $display("FAIL d3_seg cyc=%0d got=%h exp=%h", k, seg_out_b, ref_seg(k, 5, 1, m_en, m_seg)); end
            checks++; if (frame_tick_b !== ref_frame(k, 3, 5)) begin errors++; $display("FAIL d3_frame cyc=%0d got=%b exp=%b", k, frame_tick_b, ref_frame(k, 3, 5)); end
            if (k >= 45 && $urandom_range(0, 2) == 0) begin seg_in_b = 24'($urandom); digit_en_b = 3'($urandom_range(0, 7)); end
            if (k % 5 == 0) begin m_seg = seg_in_b[ref_idx(k, 3, 5) * 8 +: 8]; m_en = digit_en_b[ref_idx(k, 3, 5)]; end
        end
    endtask

    // sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        seg_in = '0;
        digit_en = '0;
        seg_in_b = '0;
        digit_en_b = '0;
        test_reset();
        test_basic();
        test_disabled();
        test_no_tear();
        test_random();
        test_async_reset();
        test_three_digit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
